// File: rtl/param_measure_pkg.sv
// Shared types for param_measure_mc: FSM state encoding and result flag bit positions.
// Optional duty-cycle feature is enabled elsewhere with PARAM_MEASURE_DUTY_EN.
package param_measure_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FLAG_NO_SAMPLES = 1;
    localparam int FLAG_FEW_EDGES  = 0;

endpackage

// File: rtl/param_measure_mc_hyst_edge_det.sv
// Per-channel hysteresis comparator: tracks high/low state, first-sample seen bit and rising-edge pulse.
// With PARAM_MEASURE_DUTY_EN defined, the post-update comparator state is exported for duty counting.
module hyst_edge_det #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          smp,
    input  logic [DW-1:0] data,
    input  logic [DW-1:0] hi,
    input  logic [DW-1:0] lo,
    output logic          seen,
    output logic          edge_pulse
`ifdef PARAM_MEASURE_DUTY_EN
    ,
    output logic          state_nxt
`endif
);

    logic level_hi;
    logic level_nxt;

    always_comb begin
        level_nxt  = level_hi;
        edge_pulse = 1'b0;
        if (smp) begin
            // the first sample only initialises the state, it never counts as an edge
            if (!seen) begin
                level_nxt = (data >= hi);
            end else if (!level_hi && (data >= hi)) begin
                level_nxt  = 1'b1;
                edge_pulse = 1'b1;
            end else if (level_hi && (data <= lo)) begin
                level_nxt = 1'b0;
            end
        end
    end

`ifdef PARAM_MEASURE_DUTY_EN
    assign state_nxt = level_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            seen     <= 1'b0;
            level_hi <= 1'b0;
        end else if (smp) begin
            seen     <= 1'b1;
            level_hi <= level_nxt;
        end
    end

endmodule

// File: rtl/param_measure_mc.sv
// Gated multi-channel parameter measurement: peak/min, hysteresis edge count and edge span per channel.
// Define PARAM_MEASURE_DUTY_EN to add the res_duty output (count of samples with comparator high).
//
//   state | meaning
//   IDLE  | waiting for start; thresholds latched and statistics cleared on start
//   RUN   | gate open for GATE_CYC cycles, samples accumulated
//   DRAIN | results presented channel by channel with valid/ready
module param_measure_mc
    import param_measure_pkg::*;
#(
    parameter int DW       = 8,
    parameter int NCH      = 4,
    parameter int GATE_CYC = 50_000_000,
    parameter int EW       = 20,
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int SW      = $clog2(GATE_CYC + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] trig_level,
    input  logic [DW-1:0] hyst,
    input  logic          start,
    input  logic          ad_valid,
    input  logic [CW-1:0] ad_chan,
    input  logic [DW-1:0] ad_data,
    output logic          busy,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [CW-1:0] res_chan,
    output logic [DW-1:0] res_max,
    output logic [DW-1:0] res_min,
    output logic [DW-1:0] res_vpp,
    output logic [EW-1:0] res_edges,
    output logic [SW-1:0] res_span,
    output logic [1:0]    res_flags
`ifdef PARAM_MEASURE_DUTY_EN
    ,
    output logic [SW-1:0] res_duty
`endif
);

    state_t        state, state_nxt;
    logic [SW-1:0] g;
    logic [CW-1:0] ptr;
    logic [DW-1:0] lvl_q, hyst_q;
    logic [DW:0]   sum;
    logic [DW-1:0] hi, lo;
    logic          gate_clr;
    logic          acc;

    logic [NCH-1:0] smp, seen, edge_p;
    logic [DW-1:0]  max_a   [NCH];
    logic [DW-1:0]  min_a   [NCH];
    logic [EW-1:0]  edges_a [NCH];
    logic [SW-1:0]  first_a [NCH];
    logic [SW-1:0]  last_a  [NCH];
`ifdef PARAM_MEASURE_DUTY_EN
    logic [NCH-1:0] hi_nxt;
    logic [SW-1:0]  duty_a  [NCH];
`endif

    assign sum = {1'b0, lvl_q} + {1'b0, hyst_q};
    assign hi  = sum[DW] ? '1 : sum[DW-1:0];
    assign lo  = (lvl_q > hyst_q) ? (lvl_q - hyst_q) : '0;
    assign acc = (state == RUN) && ad_valid && (int'(ad_chan) < NCH);

    always_comb begin
        state_nxt = state;
        gate_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    gate_clr  = 1'b1;
                end
            end
            RUN: begin
                if (g == SW'(GATE_CYC - 1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                // start is not looked at here, so a start on the final handshake is dropped
                if (res_ready && (ptr == CW'(NCH - 1))) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            g      <= '0;
            ptr    <= '0;
            lvl_q  <= '0;
            hyst_q <= '0;
        end else begin
            state <= state_nxt;
            if (gate_clr) begin
                lvl_q  <= trig_level;
                hyst_q <= hyst;
                g      <= '0;
                ptr    <= '0;
            end else if (state == RUN) begin
                g <= g + 1'b1;
            end
            if ((state == DRAIN) && res_ready)
                ptr <= (ptr == CW'(NCH - 1)) ? '0 : ptr + 1'b1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DW-1:0] max_q, min_q;
        logic [EW-1:0] edges_q;
        logic [SW-1:0] first_q, last_q;

        assign smp[i] = acc && (ad_chan == CW'(i));

        hyst_edge_det #(.DW(DW)) u_det (
            .clk        (clk),
            .rst_n      (rst_n),
            .clr        (gate_clr),
            .smp        (smp[i]),
            .data       (ad_data),
            .hi         (hi),
            .lo         (lo),
            .seen       (seen[i]),
            .edge_pulse (edge_p[i])
`ifdef PARAM_MEASURE_DUTY_EN
            ,
            .state_nxt  (hi_nxt[i])
`endif
        );

        always_ff @(posedge clk) begin
            if (!rst_n || gate_clr) begin
                max_q   <= '0;
                min_q   <= '0;
                edges_q <= '0;
                first_q <= '0;
                last_q  <= '0;
            end else if (smp[i]) begin
                if (!seen[i] || (ad_data > max_q)) max_q <= ad_data;
                if (!seen[i] || (ad_data < min_q)) min_q <= ad_data;
                if (edge_p[i]) begin
                    if (edges_q != '1) edges_q <= edges_q + 1'b1;
                    if (edges_q == '0) first_q <= g;
                    last_q <= g;
                end
            end
        end

`ifdef PARAM_MEASURE_DUTY_EN
        logic [SW-1:0] duty_q;
        always_ff @(posedge clk) begin
            if (!rst_n || gate_clr) duty_q <= '0;
            else if (smp[i] && hi_nxt[i]) duty_q <= duty_q + 1'b1;
        end
        assign duty_a[i] = duty_q;
`endif

        assign max_a[i]   = max_q;
        assign min_a[i]   = min_q;
        assign edges_a[i] = edges_q;
        assign first_a[i] = first_q;
        assign last_a[i]  = last_q;
    end

    // A channel without samples reports only the no-samples flag; edge flag needs data to mean anything.
    always_comb begin
        busy      = (state != IDLE);
        res_valid = (state == DRAIN);
        res_chan  = '0;
        res_max   = '0;
        res_min   = '0;
        res_vpp   = '0;
        res_edges = '0;
        res_span  = '0;
        res_flags = '0;
`ifdef PARAM_MEASURE_DUTY_EN
        res_duty  = '0;
`endif
        if (state == DRAIN) begin
            res_chan = ptr;
            if (!seen[ptr]) begin
                res_flags[FLAG_NO_SAMPLES] = 1'b1;
            end else begin
                res_max   = max_a[ptr];
                res_min   = min_a[ptr];
                res_vpp   = max_a[ptr] - min_a[ptr];
                res_edges = edges_a[ptr];
`ifdef PARAM_MEASURE_DUTY_EN
                res_duty  = duty_a[ptr];
`endif
                if (edges_a[ptr] < EW'(2)) res_flags[FLAG_FEW_EDGES] = 1'b1;
                else res_span = last_a[ptr] - first_a[ptr];
            end
        end
    end

endmodule

// File: tb/tb_param_measure_mc.sv
// Scoreboard bench for param_measure_mc: single-channel and four-channel instances, 1000-cycle gates.
// Duty checks are included when PARAM_MEASURE_DUTY_EN is defined.
module tb_param_measure_mc;

    typedef struct {
        int chan;
        int mx;
        int mn;
        int vpp;
        int edges;
        int span;
        int flags;
        int duty;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] trig_level, hyst, ad_data;
    logic       ad_valid;
    logic       start_a, start_b, res_ready_a, res_ready_b;
    logic [0:0] ad_chan_a;
    logic [1:0] ad_chan_b;

    logic        busy_a, res_valid_a, busy_b, res_valid_b;
    logic [0:0]  res_chan_a;
    logic [1:0]  res_chan_b;
    logic [7:0]  res_max_a, res_min_a, res_vpp_a, res_max_b, res_min_b, res_vpp_b;
    logic [19:0] res_edges_a, res_edges_b;
    logic [9:0]  res_span_a, res_span_b;
    logic [1:0]  res_flags_a, res_flags_b;
`ifdef PARAM_MEASURE_DUTY_EN
    logic [9:0]  res_duty_a, res_duty_b;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    param_measure_mc #(.DW(8), .NCH(1), .GATE_CYC(1000)) u_a (
        .clk(clk), .rst_n(rst_n), .trig_level(trig_level), .hyst(hyst), .start(start_a),
        .ad_valid(ad_valid), .ad_chan(ad_chan_a), .ad_data(ad_data), .busy(busy_a),
        .res_valid(res_valid_a), .res_ready(res_ready_a), .res_chan(res_chan_a),
        .res_max(res_max_a), .res_min(res_min_a), .res_vpp(res_vpp_a),
        .res_edges(res_edges_a), .res_span(res_span_a), .res_flags(res_flags_a)
`ifdef PARAM_MEASURE_DUTY_EN
        , .res_duty(res_duty_a)
`endif
    );

    param_measure_mc #(.DW(8), .NCH(4), .GATE_CYC(1000)) u_b (
        .clk(clk), .rst_n(rst_n), .trig_level(trig_level), .hyst(hyst), .start(start_b),
        .ad_valid(ad_valid), .ad_chan(ad_chan_b), .ad_data(ad_data), .busy(busy_b),
        .res_valid(res_valid_b), .res_ready(res_ready_b), .res_chan(res_chan_b),
        .res_max(res_max_b), .res_min(res_min_b), .res_vpp(res_vpp_b),
        .res_edges(res_edges_b), .res_span(res_span_b), .res_flags(res_flags_b)
`ifdef PARAM_MEASURE_DUTY_EN
        , .res_duty(res_duty_b)
`endif
    );

    task automatic cmp(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic check_res(input string tag, input exp_t e, input int chan, input int mx,
                             input int mn, input int vpp, input int edges, input int span,
                             input int flags, input int duty);
        cmp({tag, "_chan"}, chan, e.chan);
        cmp({tag, "_max"}, mx, e.mx);
        cmp({tag, "_min"}, mn, e.mn);
        cmp({tag, "_vpp"}, vpp, e.vpp);
        cmp({tag, "_edges"}, edges, e.edges);
        cmp({tag, "_span"}, span, e.span);
        cmp({tag, "_flags"}, flags, e.flags);
`ifdef PARAM_MEASURE_DUTY_EN
        cmp({tag, "_duty"}, duty, e.duty);
`else
        if (duty != 0) $display("note: unexpected duty argument %0d", duty);
`endif
    endtask

    always @(negedge clk) begin
        if (rst_n && res_valid_a && res_ready_a) begin
            if (qa.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL A_unexpected_result: got chan %0d expected none", res_chan_a);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check_res("A", e, int'(res_chan_a), int'(res_max_a), int'(res_min_a), int'(res_vpp_a),
                          int'(res_edges_a), int'(res_span_a), int'(res_flags_a),
`ifdef PARAM_MEASURE_DUTY_EN
                          int'(res_duty_a));
`else
                          0);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && res_valid_b && res_ready_b) begin
            if (qb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL B_unexpected_result: got chan %0d expected none", res_chan_b);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check_res("B", e, int'(res_chan_b), int'(res_max_b), int'(res_min_b), int'(res_vpp_b),
                          int'(res_edges_b), int'(res_span_b), int'(res_flags_b),
`ifdef PARAM_MEASURE_DUTY_EN
                          int'(res_duty_b));
`else
                          0);
`endif
            end
        end
    end

    // sample k of a gate is driven in the cycle where the gate counter equals k
    function automatic void stim(input int mode, input int k, output logic v,
                                 output logic [1:0] ch, output logic [7:0] d);
        v = 1'b1; ch = 2'd0; d = 8'd0;
        case (mode)
            0: d = (((k / 50) % 2) != 0) ? 8'd255 : 8'd0;
            1: d = 8'(125 + (k % 11));
            2: d = (k < 500) ? 8'd239 : 8'd255;
            3, 4: begin
                ch = 2'(k % 4);
                v  = (ch != 2'd2);
                case (ch)
                    2'd0:    d = 8'd200;
                    2'd1:    d = (((k / 100) % 2) != 0) ? 8'd255 : 8'd0;
                    default: d = (((k / 4) % 2) != 0) ? 8'd150 : 8'd100;
                endcase
            end
            default: begin
                v = ((k % 4) == 0);
                d = 8'd60;
            end
        endcase
    endfunction

    task automatic run_gate(input bit on_b, input int mode, input int ncyc, input int lvl, input int hy);
        logic v;
        logic [1:0] ch;
        logic [7:0] d;
        trig_level = 8'(lvl);
        hyst       = 8'(hy);
        if (on_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk) #1;
        start_a = 1'b0; start_b = 1'b0;
        trig_level = 8'd0; hyst = 8'd0;
        for (int k = 0; k < ncyc; k++) begin
            stim(mode, k, v, ch, d);
            ad_valid = v; ad_chan_a = ch[0]; ad_chan_b = ch; ad_data = d;
            @(posedge clk) #1;
        end
        ad_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; trig_level = 8'd0; hyst = 8'd0; ad_data = 8'd0; ad_valid = 1'b0;
        start_a = 1'b0; start_b = 1'b0; ad_chan_a = 1'b0; ad_chan_b = 2'd0;
        res_ready_a = 1'b1; res_ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_busy_a", busy_a, 0);
        cmp("rst_valid_a", res_valid_a, 0);
        cmp("rst_max_a", res_max_a, 0);
        cmp("rst_edges_a", res_edges_a, 0);
        cmp("rst_busy_b", busy_b, 0);
        cmp("rst_valid_b", res_valid_b, 0);
        cmp("rst_flags_b", res_flags_b, 0);
        cmp("rst_span_b", res_span_b, 0);
        rst_n = 1'b1;
        @(posedge clk) #1;

        qa.push_back('{0, 255, 0, 255, 10, 900, 0, 500});
        run_gate(1'b0, 0, 1000, 128, 10);
        cmp("A_square_latency_valid", res_valid_a, 1);
        @(posedge clk) #1;
        cmp("A_square_back_idle", busy_a, 0);

        qa.push_back('{0, 135, 125, 10, 0, 0, 1, 0});
        run_gate(1'b0, 1, 1000, 128, 10);
        @(posedge clk) #1;

        qa.push_back('{0, 255, 239, 16, 1, 0, 1, 500});
        run_gate(1'b0, 2, 1000, 250, 10);
        @(posedge clk) #1;

        qb.push_back('{0, 200, 200, 0, 0, 0, 1, 250});
        qb.push_back('{1, 255, 0, 255, 5, 800, 0, 125});
        qb.push_back('{2, 0, 0, 0, 0, 0, 2, 0});
        qb.push_back('{3, 150, 100, 50, 125, 992, 0, 125});
        run_gate(1'b1, 3, 1000, 128, 10);
        cmp("B_first_valid", res_valid_b, 1);
        cmp("B_first_chan", res_chan_b, 0);
        @(posedge clk) #1;
        res_ready_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmp("B_stall_valid", res_valid_b, 1);
            cmp("B_stall_chan", res_chan_b, 1);
            cmp("B_stall_edges", res_edges_b, 5);
            cmp("B_stall_span", res_span_b, 800);
            cmp("B_stall_max", res_max_b, 255);
            start_b = (i == 2);
            @(posedge clk) #1;
        end
        start_b = 1'b0;
        res_ready_b = 1'b1;
        @(posedge clk) #1;
        cmp("B_after_hs_chan", res_chan_b, 2);
        cmp("B_after_hs_valid", res_valid_b, 1);
        @(posedge clk) #1;
        cmp("B_last_chan", res_chan_b, 3);
        start_b = 1'b1;
        @(posedge clk) #1;
        start_b = 1'b0;
        cmp("B_final_start_busy", busy_b, 0);
        cmp("B_final_start_valid", res_valid_b, 0);
        @(posedge clk) #1;
        cmp("B_idle_stays", busy_b, 0);

        run_gate(1'b1, 4, 500, 128, 10);
        rst_n = 1'b0;
        @(posedge clk) #1;
        cmp("B_abort_busy", busy_b, 0);
        cmp("B_abort_valid", res_valid_b, 0);
        rst_n = 1'b1;
        @(posedge clk) #1;
        cmp("B_abort_no_result", res_valid_b, 0);

        qb.push_back('{0, 60, 60, 0, 0, 0, 1, 0});
        qb.push_back('{1, 0, 0, 0, 0, 0, 2, 0});
        qb.push_back('{2, 0, 0, 0, 0, 0, 2, 0});
        qb.push_back('{3, 0, 0, 0, 0, 0, 2, 0});
        run_gate(1'b1, 5, 1000, 128, 10);
        repeat (6) @(posedge clk);
        #1;
        cmp("B_fresh_idle", busy_b, 0);

        cmp("A_queue_left", qa.size(), 0);
        cmp("B_queue_left", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/param_measure_mc.md
PARAM_MEASURE_MC -- requirements
Module: param_measure_mc

Interface
REQ-001 Parameter DW, default 8: sample width in bits.
REQ-002 Parameter NCH, default 4: number of time-multiplexed channels; legal range 1..16.
REQ-003 Parameter GATE_CYC, default 50_000_000: gate length in clk cycles.
REQ-004 Parameter EW, default 20: edge-counter width.
REQ-005 Localparams: CW = max(1, clog2(NCH)); SW = clog2(GATE_CYC+1).
REQ-006 Ports, clock and reset first:
  clk  in  1  sole clock; all logic is synchronous to it.
  rst_n  in  1  reset; synchronous, active-low.
  trig_level  in  DW  trigger level; sampled at gate start.
  hyst  in  DW  hysteresis half-width; sampled at gate start.
  start  in  1  one-cycle request to open a gate.
  ad_valid  in  1  sample strobe.
  ad_chan  in  CW  channel index of ad_data.
  ad_data  in  DW  sample value, unsigned.
  busy  out  1  high in RUN and DRAIN.
  res_valid  out  1  result available.
  res_ready  in  1  downstream accepts the result.
  res_chan  out  CW  channel of the current result.
  res_max / res_min / res_vpp  out  DW each  peak statistics.
  res_edges  out  EW  count of qualified rising crossings.
  res_span  out  SW  clk cycles from first to last counted edge.
  res_flags  out  2  bit1 = no samples, bit0 = fewer than 2 edges.

Function
REQ-007 FSM states: IDLE, RUN, DRAIN; reset state is IDLE.
REQ-008 IDLE->RUN on start=1, which also latches trig_level/hyst and clears all per-channel statistics.
REQ-009 RUN lasts exactly GATE_CYC cycles, counted by gate counter g (0..GATE_CYC-1); RUN->DRAIN after the cycle with g=GATE_CYC-1.
REQ-010 Samples are accepted only in RUN with ad_valid=1 and ad_chan<NCH; all other samples are ignored.
REQ-011 Thresholds: hi = min(level+hyst, 2^DW-1) and lo = max(level-hyst, 0), both saturating.
REQ-012 Per-channel comparator state: the first accepted sample sets it (high iff data>=hi) and counts no edge; afterwards, low->high when data>=hi and high->low when data<=lo, otherwise the state holds.
REQ-013 Each low->high transition is one edge: it increments edges (saturating at 2^EW-1), stores g as first_g if it is the first edge, and always stores g as last_g.
REQ-014 Max and min update on every accepted sample; vpp = max-min is computed at result time and is never negative.
REQ-015 DRAIN presents channels 0..NCH-1 in ascending order, with res_valid=1 held and all fields stable until res_ready=1.
REQ-016 The channel advances on the cycle after the res_valid&res_ready handshake; after channel NCH-1 is accepted, the FSM returns to IDLE.
REQ-017 The first result is valid on the cycle after RUN ends (1-cycle latency).
REQ-018 Channel with no samples: res_flags[1]=1 and max=min=vpp=0.
REQ-019 edges<2: res_flags[0]=1 and res_span=0; otherwise res_span = last_g-first_g.
REQ-020 start is ignored while busy=1.
REQ-021 Simultaneous res_ready=1 and start=1 on the final handshake: start is ignored.

Reset
REQ-022 When rst_n=0 at a clk edge: FSM to IDLE, all counters and statistics cleared.
REQ-023 Output reset values: busy=0, res_valid=0, and all res_* fields 0.
REQ-024 Reset asserted mid-RUN or mid-DRAIN aborts the gate; no partial result is emitted.

Configuration
REQ-025 Macro PARAM_MEASURE_DUTY_EN: when defined, the block adds output res_duty (SW wide) holding the count of accepted samples with comparator state high, reset value 0, set to 0 for no-sample channels.
REQ-026 When PARAM_MEASURE_DUTY_EN is undefined, the res_duty port and its counters do not exist, and all other behaviour is identical.

Structure
REQ-027 Shared package param_measure_pkg holds the FSM state enum and the res_flags bit-index constants.
REQ-028 Sub-module hyst_edge_det (one instance per channel, generate loop) holds the comparator state, seen bit and edge pulse; the top holds the FSM, gate counter and statistics arrays.

Verification
REQ-029 NCH=1, GATE_CYC=1000, level=128, hyst=10, valid every cycle, square wave 0/255 with period 100 -> edges=10, span=900, max=255, min=0, vpp=255, flags=0.
REQ-030 Samples oscillating 125..135 with level=128 and hyst=10 -> edges=0, flags=01, span=0.
REQ-031 NCH=4 with channel 2 never driven -> channel 2 result flags=10 and max=min=vpp=0; channels presented in order 0,1,2,3.
REQ-032 res_ready held low 5 cycles on channel 1 -> fields stable, then channel 2 appears on the cycle after the handshake; start pulses during DRAIN are ignored.
REQ-033 rst_n=0 at g=500 -> busy=0 the next cycle, no res_valid; a fresh start gives results unaffected by the aborted gate.
REQ-034 level=250, hyst=10 -> hi saturates at 255; a sample of 255 after 239 counts one edge.
